// File: rtl/hashin_unpack.sv
// Consumer side of the hashin FIFO: locks on a header word, assembles the
// payload words into one block header and hands it to the hash core.
module hashin_unpack #(
  parameter logic [63:0] HDR_WORD      = 64'h8000000000000280,
  parameter int unsigned PAYLOAD_WORDS = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stop,
  input  logic [63:0]                 fifo_dout,
  input  logic                        fifo_empty,
  output logic                        fifo_rd_en,
  output logic [64*PAYLOAD_WORDS-1:0] msg_data,
  output logic [31:0]                 msg_nonce,
  output logic                        msg_valid,
  input  logic                        msg_ready,
  output logic                        stop_ack_unpack,
  output logic [31:0]                 msg_count,
  output logic [15:0]                 sync_err_count
);

  localparam int unsigned MSG_W = 64 * PAYLOAD_WORDS;
  localparam int unsigned CW    = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

  typedef enum logic [1:0] {S_SYNC, S_LOAD, S_PRESENT, S_FLUSH} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [MSG_W-1:0] r_msg;
  logic [31:0]      r_nonce;
  logic [31:0]      r_msg_count;
  logic [15:0]      r_sync_err;
  logic             w_pop, w_accept, w_last, w_is_hdr;

  always_comb begin
    w_pop    = (r_state != S_PRESENT) && !fifo_empty;
    w_accept = (r_state == S_PRESENT) && msg_ready;
    w_last   = (r_cnt == CW'(PAYLOAD_WORDS - 1));
    w_is_hdr = (fifo_dout == HDR_WORD);
    w_next   = r_state;
    if (stop) begin
      w_next = S_FLUSH;
    end else begin
      unique case (r_state)
        S_SYNC:    if (w_pop && w_is_hdr) w_next = S_LOAD;
        S_LOAD:    if (w_pop && w_last)   w_next = S_PRESENT;
        S_PRESENT: if (msg_ready)         w_next = S_SYNC;
        S_FLUSH:   if (fifo_empty)        w_next = S_SYNC;
        default:                          w_next = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SYNC;
      r_cnt       <= '0;
      r_msg       <= '0;
      r_nonce     <= '0;
      r_msg_count <= '0;
      r_sync_err  <= '0;
    end else begin
      r_state <= w_next;
      // A handshake in the cycle stop first appears still completes.
      if (w_accept) r_msg_count <= r_msg_count + 32'd1;
      if (r_state == S_SYNC) begin
        r_cnt <= '0;
        if (w_pop && !stop && !w_is_hdr && (r_sync_err != '1))
          r_sync_err <= r_sync_err + 16'd1;
      end
      if ((r_state == S_LOAD) && w_pop && !stop) begin
        for (int unsigned i = 0; i < PAYLOAD_WORDS; i++)
          if (r_cnt == CW'(i)) r_msg[MSG_W-1-64*i -: 64] <= fifo_dout;
        r_cnt <= r_cnt + CW'(1);
        if (w_last)
          r_nonce <= {fifo_dout[7:0], fifo_dout[15:8], fifo_dout[23:16], fifo_dout[31:24]};
      end
    end
  end

  assign fifo_rd_en      = w_pop;
  assign msg_data        = r_msg;
  assign msg_nonce       = r_nonce;
  assign msg_valid       = (r_state == S_PRESENT);
  assign stop_ack_unpack = (r_state == S_FLUSH) && fifo_empty;
  assign msg_count       = r_msg_count;
  assign sync_err_count  = r_sync_err;

endmodule

// File: tb/tb_hashin_unpack.sv
// Directed bench for hashin_unpack: FIFO model plus a scoreboard of expected
// messages compared on each accepted handshake.
module tb_hashin_unpack;

  localparam logic [63:0] HDR = 64'h8000000000000280;

  logic         clk = 1'b0;
  logic         rst, stop, fifo_empty, fifo_rd_en, msg_valid, msg_ready, stop_ack_unpack;
  logic [63:0]  fifo_dout;
  logic [639:0] msg_data;
  logic [31:0]  msg_nonce, msg_count;
  logic [15:0]  sync_err_count;

  always #5 clk = ~clk;

  hashin_unpack #(.HDR_WORD(HDR), .PAYLOAD_WORDS(10)) dut (
    .clk(clk), .rst(rst), .stop(stop),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .msg_data(msg_data), .msg_nonce(msg_nonce), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .stop_ack_unpack(stop_ack_unpack),
    .msg_count(msg_count), .sync_err_count(sync_err_count)
  );

  logic [63:0]  q[$];
  logic [639:0] sb_data[$];
  logic [31:0]  sb_nonce[$];
  int           checks = 0, failures = 0, pops = 0, accepts = 0;
  int           n, m, p0;
  logic         rd_s = 1'b0;
  logic [639:0] held;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : 64'h0;
  endtask

  // One clock: sample in the low phase, pop the FIFO model at the edge.
  task automatic cyc();
    logic [639:0] ed;
    logic [31:0]  en;
    refresh();
    #1;
    rd_s = fifo_rd_en;
    if (rd_s && fifo_empty) chk("rd_en_while_empty", rd_s, 1'b0);
    if (msg_valid && msg_ready && !rst) begin
      accepts++;
      chk("sb_has_entry", (sb_data.size() > 0), 1'b1);
      if (sb_data.size() > 0) begin
        ed = sb_data.pop_front();
        en = sb_nonce.pop_front();
        chk("msg_data", msg_data, ed);
        chk("msg_nonce", msg_nonce, en);
      end
    end
    @(posedge clk);
    if (rd_s && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    @(negedge clk);
    refresh();
  endtask

  task automatic sb_add(input logic [63:0] base);
    logic [639:0] d;
    logic [63:0]  w;
    d = '0;
    for (int i = 1; i <= 10; i++) begin
      w = base + 64'(i);
      d = {d[575:0], w};
    end
    sb_data.push_back(d);
    sb_nonce.push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
  endtask

  task automatic push_words(input logic [63:0] base, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) q.push_back(base + 64'(i));
    refresh();
  endtask

  task automatic push_msg(input logic [63:0] base);
    q.push_back(HDR);
    push_words(base, 1, 10);
    sb_add(base);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!msg_valid && cnt < 60) begin
      cyc();
      cnt++;
    end
    chk("valid_timeout", msg_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; msg_ready = 1'b0;
    refresh();
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", msg_valid, 1'b0);
    chk("rst_data", msg_data, '0);
    chk("rst_nonce", msg_nonce, 32'h0);
    chk("rst_ack", stop_ack_unpack, 1'b0);
    chk("rst_cnt", msg_count, 32'h0);
    chk("rst_err", sync_err_count, 16'h0);

    // basic message, latency from header pop
    msg_ready = 1'b1;
    push_msg(64'h0);
    wait_valid(n);
    chk("latency", n, 11);
    chk("data_first", msg_data[639:576], 64'h1);
    chk("data_last", msg_data[63:0], 64'hA);
    chk("nonce_val", msg_nonce, 32'h0A000000);
    cyc();
    chk("t1_count", msg_count, 32'd1);
    chk("t1_valid_drop", msg_valid, 1'b0);

    // back-pressure for 5 cycles; garbage queued behind so rd_en is meaningful
    msg_ready = 1'b0;
    push_msg(64'h0);
    wait_valid(n);
    held = msg_data;
    q.push_back(64'h1234); q.push_back(64'h5678); q.push_back('1);
    refresh();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", msg_valid, 1'b1);
      chk("stall_data", msg_data, held);
      chk("stall_rd_en", rd_s, 1'b0);
    end
    chk("stall_count", msg_count, 32'd1);
    msg_ready = 1'b1;
    cyc();
    chk("t2_count", msg_count, 32'd2);

    // garbage words then a valid message
    push_msg(64'h100);
    wait_valid(n);
    cyc();
    chk("sync_err", sync_err_count, 16'd3);
    chk("t3_count", msg_count, 32'd3);

    // stop mid-message with words still arriving
    q.push_back(HDR);
    push_words(64'h300, 1, 4);
    for (int i = 0; i < 5; i++) cyc();
    stop = 1'b1;
    cyc();
    chk("stop_valid", msg_valid, 1'b0);
    p0 = pops;
    push_words(64'h300, 5, 7);
    for (int i = 0; i < 5; i++) cyc();
    chk("flush_pops", pops - p0, 3);
    chk("flush_ack", stop_ack_unpack, 1'b1);
    stop = 1'b0;
    cyc();
    chk("ack_clear", stop_ack_unpack, 1'b0);
    chk("stop_count", msg_count, 32'd3);
    chk("stop_err", sync_err_count, 16'd3);

    // 3-cycle FIFO gap between payload words 5 and 6
    q.push_back(HDR);
    push_words(64'h400, 1, 5);
    sb_add(64'h400);
    for (int i = 0; i < 6; i++) cyc();
    p0 = pops;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gap_valid", msg_valid, 1'b0);
    end
    chk("gap_pops", pops - p0, 0);
    push_words(64'h400, 6, 10);
    wait_valid(m);
    chk("gap_latency", 9 + m, 14);
    cyc();
    chk("t5_count", msg_count, 32'd4);

    // reset after 7 payload words, then a fresh message
    q.push_back(HDR);
    push_words(64'hDEAD0000, 1, 7);
    for (int i = 0; i < 8; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_count", msg_count, 32'h0);
    chk("mrst_err", sync_err_count, 16'h0);
    chk("mrst_valid", msg_valid, 1'b0);
    chk("mrst_data", msg_data, '0);
    chk("mrst_nonce", msg_nonce, 32'h0);
    push_msg(64'h500);
    wait_valid(n);
    cyc();
    chk("t6_count", msg_count, 32'd1);
    chk("sb_drained", sb_data.size(), 0);
    chk("accepts", accepts, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hashin_unpack.md
Name: hashin_unpack

Overview:
- Downstream of the nonce generator; consumer side of the hashin FIFO.
- Pops the 11-word-per-nonce stream from the FIFO: one 64-bit header word, then ten 64-bit payload words.
- Validates the header word, then assembles the ten payload words into one 640-bit block header.
- Presents that block, plus the recovered nonce, to the hash core over a valid/ready handshake. Also handles resync after corrupt or partial streams and a stop/flush request.

Parameters:
- HDR_WORD, 64'h8000000000000280, exact value a header word must match (bit63 start flag, low bits = 640-bit length).
- PAYLOAD_WORDS, 10, payload words per message; message width = 64*PAYLOAD_WORDS.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- stop  input  1  stop request, level, from control.
- fifo_dout  input  64  hashin FIFO read data; first-word-fall-through, valid whenever fifo_empty=0.
- fifo_empty  input  1  hashin FIFO empty flag.
- fifo_rd_en  output  1  pop strobe; asserted only when fifo_empty=0.
- msg_data  output  640  assembled block header; first payload word at [639:576], last at [63:0].
- msg_nonce  output  32  byte-reversed msg_data[31:0], i.e. the native nonce value.
- msg_valid  output  1  msg_data/msg_nonce valid.
- msg_ready  input  1  hash core accepts when msg_valid && msg_ready.
- stop_ack_unpack  output  1  flush complete.
- msg_count  output  32  messages accepted by the hash core; wraps.
- sync_err_count  output  16  rejected (non-header) words while syncing; saturates at 16'hFFFF.

Behaviour:
- Reset: state=SYNC; fifo_rd_en=0; msg_valid=0; msg_data=0; msg_nonce=0; stop_ack_unpack=0; both counters=0. Any partial message is discarded. Reset mid-operation has the same effect.
- fifo_rd_en is combinational from state and fifo_empty. A pop occurs in every cycle with fifo_rd_en=1; the word is captured at that edge.
- SYNC:
  - fifo_rd_en = !fifo_empty.
  - Popped word == HDR_WORD: clear the word counter, go LOAD.
  - Otherwise: discard the word, increment sync_err_count (saturating), stay in SYNC.
- LOAD:
  - fifo_rd_en = !fifo_empty.
  - Each pop shifts the word into the message register at position cnt (cnt 0 lands at [639:576]) and increments cnt.
  - Empty cycles stall with no change.
  - No header check on payload words; any value is accepted.
  - The pop with cnt==PAYLOAD_WORDS-1 goes to PRESENT. msg_valid=1 from the next cycle.
  - Minimum latency from the header pop to msg_valid: 11 cycles with the FIFO never empty.
- PRESENT:
  - fifo_rd_en=0; msg_valid=1.
  - msg_data and msg_nonce are stable while msg_valid && !msg_ready.
  - On msg_valid && msg_ready: msg_valid=0 next cycle, msg_count+1, go SYNC.
  - Back-to-back messages are therefore separated by the 11-pop load time.
- msg_nonce = {msg_data[7:0], msg_data[15:8], msg_data[23:16], msg_data[31:24]}, registered together with msg_data.
- stop:
  - stop=1 in any state moves to FLUSH next cycle and overrides all other transitions.
  - msg_valid drops next cycle; the partial or held message is discarded and msg_count is not incremented.
  - A handshake completing in the same cycle stop is first seen still counts: msg_count+1.
- FLUSH:
  - fifo_rd_en = !fifo_empty. Popped words are discarded and sync_err_count is not incremented.
  - stop_ack_unpack = 1 in cycles where state==FLUSH and fifo_empty=1.
  - Exit to SYNC when fifo_empty && !stop; stop_ack_unpack=0 from then on.
- A message split by an upstream stop is recovered by SYNC: leftover payload words are counted as sync errors until the next HDR_WORD.
- Known limitation: a payload word equal to HDR_WORD while in SYNC causes a false lock. Acceptable, because the upstream stream always restarts at a header.

Test Plan:
- Header 8000000000000280, then payload words 0x0001..0x000A (each as 64-bit), FIFO never empty, msg_ready=1:
  - msg_valid rises 11 cycles after the first pop.
  - msg_data[639:576]=64'h1 and msg_data[63:0]=64'hA.
  - msg_nonce=32'h0A000000.
  - msg_count=1.
- Same stream with msg_ready=0 for 5 cycles: msg_valid and msg_data stay stable for 5 cycles, fifo_rd_en=0 throughout, a single accept follows, msg_count=1.
- Garbage words 0x1234, 0x5678, 0xFFFF…FF, then a valid 11-word message: sync_err_count=3 and one correct message is output.
- Header plus 4 payload words, then stop=1 for 6 cycles with 3 words still queued:
  - 3 pops in FLUSH; stop_ack_unpack=1 once the FIFO is empty.
  - Return to SYNC after stop falls; msg_count unchanged.
- FIFO empty for 3 cycles between payload words 5 and 6: no pops during the gap, message correct, msg_valid delayed by 3 cycles.
- rst asserted after 7 payload words, then a fresh 11-word message: counters=0 after reset, and the output contains only the fresh message data.
